// File: rtl/cache_tag_array.sv
// cache_tag_array: N-way set-associative tag/valid/dirty store with hit check, victim select and invalidation sweep
module cache_tag_array #(
    parameter  int INDEX_WIDTH = 6,
    parameter  int TAG_SIZE    = 20,
    parameter  int WAYS        = 2,
    localparam int DEPTH       = 2**INDEX_WIDTH,
    localparam int WAY_W       = $clog2(WAYS)
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   flush_i,
    output logic                   ready_o,
    input  logic                   lookup_i,
    input  logic [INDEX_WIDTH-1:0] lookup_index_i,
    input  logic [TAG_SIZE-1:0]    lookup_tag_i,
    output logic                   lookup_valid_o,
    output logic                   hit_o,
    output logic [WAY_W-1:0]       hit_way_o,
    output logic                   hit_dirty_o,
    output logic [WAY_W-1:0]       victim_way_o,
    output logic [TAG_SIZE-1:0]    victim_tag_o,
    output logic                   victim_dirty_o,
    input  logic                   write_i,
    input  logic [INDEX_WIDTH-1:0] write_index_i,
    input  logic [WAY_W-1:0]       write_way_i,
    input  logic [TAG_SIZE-1:0]    write_tag_i,
    input  logic                   write_valid_i,
    input  logic                   write_dirty_i
);
    typedef enum logic {SWEEP, IDLE} state_t;
    state_t                 state_q, state_d;
    logic [INDEX_WIDTH-1:0] cnt_q, cnt_d;
    logic [TAG_SIZE-1:0]    tag_mem [DEPTH][WAYS];
    logic [WAYS-1:0]        valid_q [DEPTH];
    logic [WAYS-1:0]        dirty_q [DEPTH];
    logic [WAY_W-1:0]       rr_q, hit_way, victim_way;
    logic [TAG_SIZE-1:0]    eff_tag [WAYS];
    logic [WAYS-1:0]        eff_valid, eff_dirty, match;
    logic                   idle, lookup_acc, write_acc, bypass;
    assign idle       = state_q == IDLE;
    assign ready_o    = idle;
    assign lookup_acc = lookup_i && idle;
    assign write_acc  = write_i && idle;
    assign bypass     = write_acc && write_index_i == lookup_index_i;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush_i) begin
            state_d = SWEEP;
            cnt_d   = '0;
        end else if (state_q == SWEEP) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = cnt_q == '1 ? IDLE : SWEEP;
        end
    end
    for (genvar w = 0; w < WAYS; w++) begin : g_way
        logic sel;
        assign sel          = bypass && write_way_i == WAY_W'(w);
        assign eff_tag[w]   = sel ? write_tag_i   : tag_mem[lookup_index_i][w];
        assign eff_valid[w] = sel ? write_valid_i : valid_q[lookup_index_i][w];
        assign eff_dirty[w] = sel ? write_dirty_i : dirty_q[lookup_index_i][w];
        assign match[w]     = eff_valid[w] && eff_tag[w] == lookup_tag_i;
    end
    always_comb begin
        hit_way    = '0;
        victim_way = rr_q;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (match[i]) hit_way = WAY_W'(i);
            if (!eff_valid[i]) victim_way = WAY_W'(i);
        end
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q        <= SWEEP;
            cnt_q          <= '0;
            rr_q           <= '0;
            lookup_valid_o <= 1'b0;
            hit_o          <= 1'b0;
            hit_way_o      <= '0;
            hit_dirty_o    <= 1'b0;
            victim_way_o   <= '0;
            victim_tag_o   <= '0;
            victim_dirty_o <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            lookup_valid_o <= lookup_acc;
            if (write_acc && write_valid_i) rr_q <= rr_q + 1'b1;
            if (lookup_acc) begin
                hit_o          <= |match;
                hit_way_o      <= hit_way;
                hit_dirty_o    <= |match && eff_dirty[hit_way];
                victim_way_o   <= victim_way;
                victim_tag_o   <= eff_tag[victim_way];
                victim_dirty_o <= eff_valid[victim_way] && eff_dirty[victim_way];
            end
        end
    end
    always_ff @(posedge clk_i) begin
        if (write_acc) tag_mem[write_index_i][write_way_i] <= write_tag_i;
    end
    always_ff @(posedge clk_i) begin
        if (state_q == SWEEP) begin
            valid_q[cnt_q] <= '0;
            dirty_q[cnt_q] <= '0;
        end else if (write_acc) begin
            valid_q[write_index_i][write_way_i] <= write_valid_i;
            dirty_q[write_index_i][write_way_i] <= write_dirty_i;
        end
    end
endmodule

// File: tb/tb_cache_tag_array.sv
// tb_cache_tag_array: random and directed checks against a set/way array model with whole-array flush
module tb_cache_tag_array;
    localparam int IW = 6, TS = 20, W = 2, D = 64, WW = 1;
    logic          clk_i = 0, rst_n_i = 0, flush_i = 0, lookup_i = 0, write_i = 0;
    logic          write_valid_i = 0, write_dirty_i = 0;
    logic [IW-1:0] lookup_index_i = 0, write_index_i = 0;
    logic [TS-1:0] lookup_tag_i = 0, write_tag_i = 0;
    logic [WW-1:0] write_way_i = 0;
    logic          ready_o, lookup_valid_o, hit_o, hit_dirty_o, victim_dirty_o;
    logic [WW-1:0] hit_way_o, victim_way_o;
    logic [TS-1:0] victim_tag_o;
    always #5 clk_i = ~clk_i;
    cache_tag_array #(.INDEX_WIDTH(IW), .TAG_SIZE(TS), .WAYS(W)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i), .ready_o(ready_o),
        .lookup_i(lookup_i), .lookup_index_i(lookup_index_i), .lookup_tag_i(lookup_tag_i),
        .lookup_valid_o(lookup_valid_o), .hit_o(hit_o), .hit_way_o(hit_way_o),
        .hit_dirty_o(hit_dirty_o), .victim_way_o(victim_way_o), .victim_tag_o(victim_tag_o),
        .victim_dirty_o(victim_dirty_o), .write_i(write_i), .write_index_i(write_index_i),
        .write_way_i(write_way_i), .write_tag_i(write_tag_i), .write_valid_i(write_valid_i),
        .write_dirty_i(write_dirty_i)
    );
    int            checks = 0, failures = 0;
    logic [TS-1:0] m_tag [D][W];
    bit            m_val [D][W], m_dirty [D][W], m_known [D][W];
    int            rr, sweep_left, e_hw, e_vw;
    bit            e_lv, e_hit, e_hd, e_vd, e_vt_known;
    logic [TS-1:0] e_vt;
    task automatic chk(string name, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask
    task automatic clear_status();
        for (int i = 0; i < D; i++)
            for (int w = 0; w < W; w++) begin
                m_val[i][w]   = 0;
                m_dirty[i][w] = 0;
            end
    endtask
    task automatic model_reset();
        clear_status();
        rr = 0; sweep_left = D;
        e_lv = 0; e_hit = 0; e_hw = 0; e_hd = 0; e_vw = 0; e_vd = 0; e_vt = 0; e_vt_known = 1;
    endtask
    task automatic check_outputs();
        chk("ready", 32'(ready_o), 32'(sweep_left == 0));
        chk("lookup_valid", 32'(lookup_valid_o), 32'(e_lv));
        chk("hit", 32'(hit_o), 32'(e_hit));
        chk("hit_way", 32'(hit_way_o), e_hw);
        chk("hit_dirty", 32'(hit_dirty_o), 32'(e_hd));
        chk("victim_way", 32'(victim_way_o), e_vw);
        chk("victim_dirty", 32'(victim_dirty_o), 32'(e_vd));
        if (e_vt_known) chk("victim_tag", 32'(victim_tag_o), 32'(e_vt));
    endtask
    task automatic step();
        bit idle  = sweep_left == 0;
        bit acc_w = write_i && idle;
        bit acc_l = lookup_i && idle;
        bit found = 0;
        int li    = int'(lookup_index_i);
        if (acc_w) begin
            m_tag[write_index_i][write_way_i]   = write_tag_i;
            m_val[write_index_i][write_way_i]   = write_valid_i;
            m_dirty[write_index_i][write_way_i] = write_dirty_i;
            m_known[write_index_i][write_way_i] = 1;
        end
        if (acc_l) begin
            e_hit = 0; e_hw = 0; e_vw = rr;
            for (int w = 0; w < W; w++) begin
                if (!e_hit && m_val[li][w] && m_tag[li][w] == lookup_tag_i) begin
                    e_hit = 1; e_hw = w;
                end
                if (!found && !m_val[li][w]) begin
                    found = 1; e_vw = w;
                end
            end
            e_hd       = e_hit && m_dirty[li][e_hw];
            e_vd       = m_val[li][e_vw] && m_dirty[li][e_vw];
            e_vt       = m_tag[li][e_vw];
            e_vt_known = m_known[li][e_vw];
        end
        e_lv = acc_l;
        if (acc_w && write_valid_i) rr = (rr + 1) % W;
        @(posedge clk_i);
        if (flush_i) begin
            clear_status();
            sweep_left = D;
        end else if (sweep_left > 0) sweep_left--;
        #1;
        check_outputs();
    endtask
    task automatic cyc();
        step();
        lookup_i = 0; write_i = 0; flush_i = 0;
    endtask
    task automatic wr(int i, int w, logic [TS-1:0] t, bit v, bit d);
        write_i = 1; write_index_i = IW'(i); write_way_i = WW'(w);
        write_tag_i = t; write_valid_i = v; write_dirty_i = d;
    endtask
    task automatic lk(int i, logic [TS-1:0] t);
        lookup_i = 1; lookup_index_i = IW'(i); lookup_tag_i = t;
    endtask
    task automatic rand_ops(int max_idx);
        if ($urandom_range(0, 2) == 0)
            wr(int'($urandom_range(0, max_idx)), int'($urandom_range(0, W - 1)),
               TS'(20'h100 + $urandom_range(0, 3)), $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 1) == 1)
            lk(int'($urandom_range(0, max_idx)), TS'(20'h100 + $urandom_range(0, 3)));
    endtask
    task automatic wait_ready(output int n);
        n = 0;
        while (!ready_o && n < 300) begin
            cyc();
            n++;
        end
    endtask
    initial begin
        int n;
        model_reset();
        #12;
        check_outputs();
        @(negedge clk_i);
        rst_n_i = 1;
        n = 0;
        while (!ready_o && n < 200) begin
            rand_ops(D - 1);
            cyc();
            n++;
        end
        chk("reset_sweep_len", n, D);
        lk(17, 20'h55555); cyc();
        chk("reset_lookup_hit", 32'(hit_o), 0);
        chk("reset_lookup_victim", 32'(victim_way_o), 0);
        wr(9, 0, 20'h11111, 1, 1); cyc();
        wr(9, 1, 20'h22222, 1, 0); cyc();
        lk(9, 20'h33333); cyc();
        chk("full_set_victim_way", 32'(victim_way_o), 0);
        chk("full_set_victim_dirty", 32'(victim_dirty_o), 1);
        chk("full_set_victim_tag", 32'(victim_tag_o), 32'h11111);
        wr(5, 1, 20'hABCDE, 1, 1); cyc();
        lk(5, 20'hABCDE); cyc();
        chk("idx5_hit", 32'(hit_o), 1);
        chk("idx5_hit_way", 32'(hit_way_o), 1);
        chk("idx5_hit_dirty", 32'(hit_dirty_o), 1);
        lk(5, 20'h12345); cyc();
        chk("idx5_miss", 32'(hit_o), 0);
        chk("idx5_miss_victim", 32'(victim_way_o), 0);
        wr(3, 0, 20'h00042, 1, 0); lk(3, 20'h00042); cyc();
        chk("bypass_hit", 32'(hit_o), 1);
        chk("bypass_hit_way", 32'(hit_way_o), 0);
        for (int k = 0; k < 400; k++) begin
            rand_ops(7);
            flush_i = $urandom_range(0, 199) == 0;
            cyc();
        end
        wait_ready(n);
        chk("random_phase_ready", 32'(ready_o), 1);
        wr(20, 0, 20'hA0A0A, 1, 1); cyc();
        wr(21, 1, 20'hB0B0B, 1, 0); cyc();
        lk(20, 20'hA0A0A); cyc();
        chk("pre_flush_hit", 32'(hit_o), 1);
        flush_i = 1; cyc();
        for (int k = 0; k < 30; k++) begin
            rand_ops(D - 1);
            cyc();
        end
        flush_i = 1; cyc();
        wait_ready(n);
        chk("flush_restart_len", n, D);
        lk(20, 20'hA0A0A); cyc();
        chk("post_flush_miss_20", 32'(hit_o), 0);
        lk(21, 20'hB0B0B); cyc();
        chk("post_flush_miss_21", 32'(hit_o), 0);
        wr(22, 0, 20'hC0C0C, 1, 1); cyc();
        lk(22, 20'hC0C0C); cyc();
        chk("pre_reset_hit", 32'(hit_o), 1);
        flush_i = 1; cyc();
        repeat (20) cyc();
        #2;
        rst_n_i = 0;
        model_reset();
        #1;
        check_outputs();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1;
        wait_ready(n);
        chk("mid_sweep_reset_len", n, D);
        lk(22, 20'hC0C0C); cyc();
        chk("post_reset_miss", 32'(hit_o), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
